hue_sequencer: RTL and testbench

//   Upstream control stage for the RGB fade datapath. Steps a six-phase colour

---
 rtl/hue_pkg.sv | 37 +++
 rtl/phase_decode.sv | 39 +++
 rtl/hue_sequencer.sv | 134 +++++++++++++
 tb/tb_hue_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hue_pkg.sv
// Shared types for the RGB fade path: ramp commands, sequencer states and
// modulo-6 colour-wheel stepping. Ramp generators import ramp_cmd_t from here.
package hue_pkg;

  typedef enum logic [2:0] {
    CMD_DEC  = 3'd0,
    CMD_INC  = 3'd1,
    CMD_HOLD = 3'd2
  } ramp_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

  localparam int unsigned NUM_PHASES = 6;
  localparam logic [2:0]  LAST_PHASE = 3'(NUM_PHASES - 1);

  function automatic logic [2:0] wheel_step(input logic [2:0] ph, input logic rev);
    logic [2:0] nxt;
    if (rev) nxt = (ph == 3'd0 || ph > LAST_PHASE) ? LAST_PHASE : ph - 3'd1;
    else     nxt = (ph >= LAST_PHASE) ? 3'd0 : ph + 3'd1;
    return nxt;
  endfunction

  function automatic ramp_cmd_t cmd_swap(input ramp_cmd_t c);
    ramp_cmd_t r;
    case (c)
      CMD_INC: r = CMD_DEC;
      CMD_DEC: r = CMD_INC;
      default: r = CMD_HOLD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/phase_decode.sv
// Colour-wheel table: phase index plus direction -> one ramp command per channel.
// Reverse traversal swaps INC/DEC on the active channel so the fade retraces.
module phase_decode
  import hue_pkg::*;
(
  input  logic [2:0] i_phase,
  input  logic       i_dir,
  output ramp_cmd_t  o_cmd_r,
  output ramp_cmd_t  o_cmd_g,
  output ramp_cmd_t  o_cmd_b
);

  ramp_cmd_t w_fwd_r;
  ramp_cmd_t w_fwd_g;
  ramp_cmd_t w_fwd_b;

  always_comb begin
    w_fwd_r = CMD_HOLD;
    w_fwd_g = CMD_HOLD;
    w_fwd_b = CMD_HOLD;
    case (i_phase)
      3'd0:    w_fwd_g = CMD_DEC;
      3'd1:    w_fwd_r = CMD_INC;
      3'd2:    w_fwd_b = CMD_DEC;
      3'd3:    w_fwd_g = CMD_INC;
      3'd4:    w_fwd_r = CMD_DEC;
      3'd5:    w_fwd_b = CMD_INC;
      default: ;
    endcase
  end

  // HOLD maps to HOLD under swap, so only the active channel changes
  always_comb begin
    o_cmd_r = i_dir ? cmd_swap(w_fwd_r) : w_fwd_r;
    o_cmd_g = i_dir ? cmd_swap(w_fwd_g) : w_fwd_g;
    o_cmd_b = i_dir ? cmd_swap(w_fwd_b) : w_fwd_b;
  end

endmodule

// File: rtl/hue_sequencer.sv
// Six-phase colour-wheel sequencer with run/pause/single-step/reverse control;
// emits registered per-channel ramp commands and a phase-boundary strobe.
module hue_sequencer
  import hue_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 2000000
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pause,
  input  logic       step,
  input  logic       reverse,
  output ramp_cmd_t  cmd_r,
  output ramp_cmd_t  cmd_g,
  output ramp_cmd_t  cmd_b,
  output logic [2:0] phase,
  output logic       phase_tick,
  output logic       running
);

  localparam int unsigned    CW         = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL_CYCLES - 1);

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [2:0]    r_phase;
  logic [2:0]    w_phase_nxt;
  logic          r_dir;
  logic          w_dir_nxt;
  logic          w_advance;
  logic          w_expiry;
  ramp_cmd_t     w_dec_r;
  ramp_cmd_t     w_dec_g;
  ramp_cmd_t     w_dec_b;
  ramp_cmd_t     r_cmd_r;
  ramp_cmd_t     r_cmd_g;
  ramp_cmd_t     r_cmd_b;
  logic          r_tick;
  logic          r_running;

  assign w_expiry = (r_count == DWELL_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        w_count_nxt = '0;
        if (en) w_state_nxt = pause ? PAUSE : RUN;
      end
      RUN: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (pause) begin
          w_state_nxt = PAUSE;
        end else if (step || w_expiry) begin
          w_advance   = 1'b1;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      PAUSE: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (step) begin
          // a step coinciding with pause release still advances, then runs
          w_advance   = 1'b1;
          w_count_nxt = '0;
          if (!pause) w_state_nxt = RUN;
        end else if (!pause) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // dir is captured only at an advance and governs both the step and the new table row
  always_comb begin
    w_dir_nxt   = w_advance ? reverse : r_dir;
    w_phase_nxt = w_advance ? wheel_step(r_phase, reverse) : r_phase;
  end

  phase_decode u_decode (
    .i_phase (w_phase_nxt),
    .i_dir   (w_dir_nxt),
    .o_cmd_r (w_dec_r),
    .o_cmd_g (w_dec_g),
    .o_cmd_b (w_dec_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_phase   <= '0;
      r_dir     <= 1'b0;
      r_cmd_r   <= CMD_HOLD;
      r_cmd_g   <= CMD_HOLD;
      r_cmd_b   <= CMD_HOLD;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_phase   <= w_phase_nxt;
      r_dir     <= w_dir_nxt;
      r_cmd_r   <= (w_state_nxt == RUN) ? w_dec_r : CMD_HOLD;
      r_cmd_g   <= (w_state_nxt == RUN) ? w_dec_g : CMD_HOLD;
      r_cmd_b   <= (w_state_nxt == RUN) ? w_dec_b : CMD_HOLD;
      r_tick    <= w_advance;
      r_running <= (w_state_nxt == RUN);
    end
  end

  assign cmd_r      = r_cmd_r;
  assign cmd_g      = r_cmd_g;
  assign cmd_b      = r_cmd_b;
  assign phase      = r_phase;
  assign phase_tick = r_tick;
  assign running    = r_running;

endmodule

// File: tb/tb_hue_sequencer.sv
// Scoreboard bench for hue_sequencer: directed scenarios plus random control
// traffic, predicted by a cycle-level behavioural model of the colour wheel.
module tb_hue_sequencer;

  localparam int DWELL = 8;

  typedef struct {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    logic [2:0] ph;
    logic       tick;
    logic       run;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic       reverse = 1'b0;
  logic [2:0] cmd_r;
  logic [2:0] cmd_g;
  logic [2:0] cmd_b;
  logic [2:0] phase;
  logic       phase_tick;
  logic       running;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  // behavioural model
  string m_mode = "IDLE";
  int    m_ph = 0;
  int    m_elapsed = 0;
  bit    m_rev = 1'b0;
  bit    m_adv = 1'b0;
  int    active_ch[6] = '{1, 0, 2, 1, 0, 2};  // 0=R 1=G 2=B

  hue_sequencer #(.DWELL_CYCLES(DWELL)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pause      (pause),
    .step       (step),
    .reverse    (reverse),
    .cmd_r      (cmd_r),
    .cmd_g      (cmd_g),
    .cmd_b      (cmd_b),
    .phase      (phase),
    .phase_tick (phase_tick),
    .running    (running)
  );

  always #5 clk = ~clk;

  function automatic exp_t predict();
    exp_t e;
    int   c;
    e.r = 3'd2; e.g = 3'd2; e.b = 3'd2;
    e.ph   = 3'(m_ph);
    e.tick = m_adv;
    e.run  = (m_mode == "RUN");
    if (m_mode == "RUN") begin
      c = (m_ph % 2) ^ int'(m_rev);  // forward: even phases fade down, odd fade up
      case (active_ch[m_ph])
        0:       e.r = 3'(c);
        1:       e.g = 3'(c);
        default: e.b = 3'(c);
      endcase
    end
    return e;
  endfunction

  task automatic model_cycle(input bit a_rst, input bit a_en, input bit a_pause,
                             input bit a_step, input bit a_rev);
    m_adv = 1'b0;
    if (a_rst) begin
      m_mode = "IDLE"; m_ph = 0; m_elapsed = 0; m_rev = 1'b0;
    end else if (!a_en) begin
      m_mode = "IDLE"; m_elapsed = 0;
    end else if (m_mode == "IDLE") begin
      m_mode = a_pause ? "PAUSE" : "RUN";
      m_elapsed = 0;
    end else if (m_mode == "RUN") begin
      if (a_pause) m_mode = "PAUSE";
      else if (a_step || m_elapsed == DWELL - 1) m_adv = 1'b1;
      else m_elapsed++;
    end else begin
      if (a_step) begin
        m_adv = 1'b1;
        if (!a_pause) m_mode = "RUN";
      end else if (!a_pause) begin
        m_mode = "RUN";
      end
    end
    if (m_adv) begin
      m_rev = a_rev;
      m_ph = (m_ph + (a_rev ? 5 : 1)) % 6;
      m_elapsed = 0;
    end
  endtask

  task automatic drive(input bit a_rst, input bit a_en, input bit a_pause,
                       input bit a_step, input bit a_rev);
    @(posedge clk);
    #2;
    rst = a_rst; en = a_en; pause = a_pause; step = a_step; reverse = a_rev;
    model_cycle(a_rst, a_en, a_pause, a_step, a_rev);
    q.push_back(predict());
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // run with fixed controls until the model reaches the wanted point, bounded
  task automatic run_until_elapsed(input int want_el, input int want_ph, input bit a_rev);
    int n = 0;
    while (!(m_mode == "RUN" && m_elapsed == want_el && (want_ph < 0 || m_ph == want_ph))
           && n < 200) begin
      drive(0, 1, 0, 0, a_rev);
      n++;
    end
    check("wait_bound", int'(n < 200), 1);
  endtask

  // monitor: every cycle #1 after the active edge, pop and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cmd_r", int'(cmd_r), int'(e.r));
        check("cmd_g", int'(cmd_g), int'(e.g));
        check("cmd_b", int'(cmd_b), int'(e.b));
        check("phase", int'(phase), int'(e.ph));
        check("phase_tick", int'(phase_tick), int'(e.tick));
        check("running", int'(running), int'(e.run));
      end
    end
  end

  initial begin
    bit r_en, r_pause, r_step, r_rev;
    // reset held, then enable and free-run forward through a full wheel
    repeat (3) drive(1, 0, 0, 0, 0);
    repeat (60) drive(0, 1, 0, 0, 0);

    // pause at count 3 for 20 cycles, then release
    run_until_elapsed(3, -1, 0);
    repeat (20) drive(0, 1, 1, 0, 0);
    repeat (12) drive(0, 1, 0, 0, 0);

    // two single steps while paused
    repeat (2) drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 0);
    repeat (2) drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 0);
    repeat (3) drive(0, 1, 1, 0, 0);
    repeat (4) drive(0, 1, 0, 0, 0);

    // reverse taken at the expiry out of phase 0 -> phase 5, blue DEC
    run_until_elapsed(DWELL - 1, 0, 0);
    repeat (30) drive(0, 1, 0, 0, 1);

    // pause on the expiry cycle: no advance
    run_until_elapsed(DWELL - 1, -1, 1);
    repeat (3) drive(0, 1, 1, 0, 1);
    repeat (4) drive(0, 1, 0, 0, 0);

    // en=0 while running, then re-enable
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (15) drive(0, 1, 0, 0, 0);

    // step while IDLE is ignored; IDLE with pause enters PAUSE
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 1);
    repeat (5) drive(0, 1, 0, 0, 0);

    // reset mid-phase
    run_until_elapsed(4, -1, 0);
    repeat (2) drive(1, 1, 0, 0, 0);
    repeat (10) drive(0, 1, 0, 0, 0);

    // randomized control traffic
    r_rev = 1'b0;
    for (int i = 0; i < 800; i++) begin
      r_en    = ($urandom_range(0, 99) < 95);
      r_pause = ($urandom_range(0, 99) < 12);
      r_step  = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 5) r_rev = ~r_rev;
      if (i > 0 && i % 15 == 0) repeat ($urandom_range(3, 12)) drive(0, 1, r_pause, 0, r_rev);
      drive(($urandom_range(0, 399) == 0), r_en, r_pause, r_step, r_rev);
    end
    repeat (10) drive(0, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
